keypad_scan_debounce: RTL

Front-end for the 4x4 matrix keypad on the calculator. Drives the column lines with an active-low walking zero and samples the row lines. Debounces the result over whole scan sweeps and hands the calculator core a 5-bit key code plus a one-cycle press strobe. Sits directly upstream of the calculator control/arithmetic logic and uses the existing key encoding: 0–15 are keys, 16 means no key.

---
 rtl/keypad_scan_debounce.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: walking-zero column drive, per-sweep lowest-code
// detection, and sweep-level press/release debounce feeding the calculator core.
module keypad_scan_debounce #(
  parameter int SCAN_CYCLES     = 50_000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SWEEPS);
  localparam logic [4:0]    NO_KEY   = 5'd16;

  typedef enum logic [1:0] {IDLE, PRESS_CHECK, HELD} state_t;

  logic [DW-1:0] div_q;
  logic [1:0]    slot_q;
  logic [3:0]    col_q;
  logic [4:0]    best_q, res_q;
  logic          eval_q;

  state_t        state_q, state_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          accept, rel_key;

  logic [4:0]    slot_code, sweep_min;
  logic          sample;

  // Lowest row wins within a slot; code = 4*row + slot.
  always_comb begin
    slot_code = NO_KEY;
    for (int r = 3; r >= 0; r--) begin
      if (!row[r]) slot_code = {1'b0, 2'(r), slot_q};
    end
    sweep_min = (slot_code < best_q) ? slot_code : best_q;
    sample    = (div_q == DIV_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      slot_q <= 2'd0;
      col_q  <= 4'b1110;
      best_q <= NO_KEY;
      res_q  <= NO_KEY;
      eval_q <= 1'b0;
    end else begin
      eval_q <= sample && (slot_q == 2'd3);
      if (sample) begin
        div_q  <= '0;
        slot_q <= slot_q + 2'd1;
        col_q  <= {col_q[2:0], col_q[3]};
        if (slot_q == 2'd3) begin
          res_q  <= sweep_min;
          best_q <= NO_KEY;
        end else begin
          best_q <= sweep_min;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= NO_KEY;
      cnt_q       <= '0;
      key_code_q  <= NO_KEY;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // FSM next state; only evaluated on the cycle after the slot-3 sample
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rel_key = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
    if (eval_q) begin
      case (state_q)
        IDLE: begin
          if (res_q != NO_KEY) begin
            cand_d = res_q;
            if (CNT_MAX == CW'(1)) begin
              accept = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = PRESS_CHECK;
            end
          end
        end
        PRESS_CHECK: begin
          if (res_q == NO_KEY) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (res_q == cand_q) begin
            if (cnt_inc == CNT_MAX) accept = 1'b1;
            else                    cnt_d  = cnt_inc;
          end else begin
            cand_d = res_q;
            cnt_d  = CW'(1);
          end
        end
        HELD: begin
          if (res_q == key_code_q) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_MAX) begin
            rel_key = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      state_d = HELD;
      cnt_d   = '0;
    end
  end

  // FSM outputs (registered on the next edge)
  always_comb begin
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    if (accept) begin
      key_code_d  = cand_d;
      key_held_d  = 1'b1;
      key_valid_d = 1'b1;
    end else if (rel_key) begin
      key_code_d = NO_KEY;
      key_held_d = 1'b0;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
